// File: rtl/lea_block_byte_serializer.sv
// Byte serializer for one 128-bit LEA block (16 parallel lanes -> 8-bit valid/ready stream).
// The block is buffered on load, so the next block may load on the edge that takes the current last byte.
module lea_block_byte_serializer #(
    parameter int BYTE_ORDER = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] Din0,
    input  logic [7:0] Din1,
    input  logic [7:0] Din2,
    input  logic [7:0] Din3,
    input  logic [7:0] Din4,
    input  logic [7:0] Din5,
    input  logic [7:0] Din6,
    input  logic [7:0] Din7,
    input  logic [7:0] Din8,
    input  logic [7:0] Din9,
    input  logic [7:0] Din10,
    input  logic [7:0] Din11,
    input  logic [7:0] Din12,
    input  logic [7:0] Din13,
    input  logic [7:0] Din14,
    input  logic [7:0] Din15,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] Dout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] blk_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state_r;
    logic [3:0] idx_r;
    logic [7:0] buf_r [16];
    logic [7:0] din_s [16];
    logic [7:0] ord_s [16];
    logic       load_s;
    logic       xfer_s;
    logic       last_s;

    // Gather the lane ports into an array.
    always_comb begin
        din_s[0]  = Din0;
        din_s[1]  = Din1;
        din_s[2]  = Din2;
        din_s[3]  = Din3;
        din_s[4]  = Din4;
        din_s[5]  = Din5;
        din_s[6]  = Din6;
        din_s[7]  = Din7;
        din_s[8]  = Din8;
        din_s[9]  = Din9;
        din_s[10] = Din10;
        din_s[11] = Din11;
        din_s[12] = Din12;
        din_s[13] = Din13;
        din_s[14] = Din14;
        din_s[15] = Din15;
    end

    // Reorder lanes into transmit order at load, so the buffer is always walked 0..15.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            if (BYTE_ORDER == 0) begin
                ord_s[i] = din_s[i];
            end else begin
                ord_s[i] = din_s[15 - i];
            end
        end
    end

    assign in_ready = (state_r == IDLE) |
                      ((state_r == SEND) & (idx_r == 4'd15) & out_ready);
    assign load_s   = in_valid & in_ready;
    assign xfer_s   = (state_r == SEND) & out_ready;
    assign last_s   = xfer_s & (idx_r == 4'd15);

    // Main state, buffer and registered output stream.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            idx_r     <= 4'd0;
            Dout      <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_r[i] <= 8'h00;
            end
        end else if (load_s) begin
            state_r   <= SEND;
            idx_r     <= 4'd0;
            Dout      <= ord_s[0];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_r[i] <= ord_s[i];
            end
        end else if (xfer_s && (idx_r != 4'd15)) begin
            idx_r    <= idx_r + 4'd1;
            Dout     <= buf_r[idx_r + 4'd1];
            out_last <= (idx_r == 4'd14);
        end else if (last_s) begin
            // Dout deliberately keeps the last byte while idle.
            state_r   <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state_r <= state_r;
        end
    end

    // Completed-block counter; a block counts only when its last byte is taken.
    always_ff @(posedge CLK) begin
        if (RST) begin
            blk_cnt <= 8'd0;
        end else if (last_s) begin
            blk_cnt <= blk_cnt + 8'd1;
        end else begin
            blk_cnt <= blk_cnt;
        end
    end

endmodule

// File: tb/tb_lea_block_byte_serializer.sv
// Directed bench: one instance per byte order, shared stimulus, hand-computed expectations.
module tb_lea_block_byte_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din [16];
    logic       in_valid;
    logic       out_ready;
    logic       in_ready0, in_ready1;
    logic [7:0] dout0, dout1;
    logic       out_valid0, out_valid1;
    logic       out_last0, out_last1;
    logic [7:0] blk_cnt0, blk_cnt1;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lea_block_byte_serializer #(.BYTE_ORDER(0)) u0 (
        .CLK(clk), .RST(rst),
        .Din0(din[0]), .Din1(din[1]), .Din2(din[2]), .Din3(din[3]),
        .Din4(din[4]), .Din5(din[5]), .Din6(din[6]), .Din7(din[7]),
        .Din8(din[8]), .Din9(din[9]), .Din10(din[10]), .Din11(din[11]),
        .Din12(din[12]), .Din13(din[13]), .Din14(din[14]), .Din15(din[15]),
        .in_valid(in_valid), .in_ready(in_ready0),
        .Dout(dout0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_last(out_last0), .blk_cnt(blk_cnt0)
    );

    lea_block_byte_serializer #(.BYTE_ORDER(1)) u1 (
        .CLK(clk), .RST(rst),
        .Din0(din[0]), .Din1(din[1]), .Din2(din[2]), .Din3(din[3]),
        .Din4(din[4]), .Din5(din[5]), .Din6(din[6]), .Din7(din[7]),
        .Din8(din[8]), .Din9(din[9]), .Din10(din[10]), .Din11(din[11]),
        .Din12(din[12]), .Din13(din[13]), .Din14(din[14]), .Din15(din[15]),
        .in_valid(in_valid), .in_ready(in_ready1),
        .Dout(dout1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_last(out_last1), .blk_cnt(blk_cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_din(input logic [7:0] base, input logic [7:0] step);
        for (int k = 0; k < 16; k++) begin
            din[k] = base + step * k[7:0];
        end
    endtask

    initial begin
        int c;
        int eidx;
        logic [7:0] e0;
        logic [7:0] e1;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_din(8'h00, 8'h00);

        // Reset and idle
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("idle_valid", {15'd0, out_valid0}, 16'd0);
            chk("idle_dout", {8'd0, dout0}, 16'h0000);
            chk("idle_in_ready", {15'd0, in_ready0}, 16'd1);
            chk("idle_blk_cnt", {8'd0, blk_cnt0}, 16'd0);
            tick();
        end

        // Single block, both byte orders
        set_din(8'h00, 8'h11);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        set_din(8'h5A, 8'h00);
        for (int i = 0; i < 16; i++) begin
            e0 = 8'h11 * i[7:0];
            e1 = 8'hFF - e0;
            chk("single_dout0", {8'd0, dout0}, {8'd0, e0});
            chk("single_dout1", {8'd0, dout1}, {8'd0, e1});
            chk("single_valid", {14'd0, out_valid0, out_valid1}, 16'd3);
            chk("single_last0", {15'd0, out_last0}, {15'd0, (i == 15)});
            chk("single_last1", {15'd0, out_last1}, {15'd0, (i == 15)});
            tick();
        end
        chk("single_end_valid", {14'd0, out_valid0, out_valid1}, 16'd0);
        chk("single_end_last", {14'd0, out_last0, out_last1}, 16'd0);
        chk("single_blk_cnt0", {8'd0, blk_cnt0}, 16'd1);
        chk("single_blk_cnt1", {8'd0, blk_cnt1}, 16'd1);
        chk("single_end_in_ready", {15'd0, in_ready0}, 16'd1);

        // Backpressure with out_ready pattern 1,0,0,1
        set_din(8'h20, 8'h01);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        set_din(8'hC3, 8'h00);
        eidx = 0;
        c = 0;
        while (eidx < 16 && c < 100) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            chk("bp_dout0", {8'd0, dout0}, {8'd0, 8'h20 + eidx[7:0]});
            chk("bp_dout1", {8'd0, dout1}, {8'd0, 8'h2F - eidx[7:0]});
            chk("bp_valid", {15'd0, out_valid0}, 16'd1);
            chk("bp_last", {15'd0, out_last0}, {15'd0, (eidx == 15)});
            chk("bp_in_ready", {15'd0, in_ready0}, {15'd0, (eidx == 15) && out_ready});
            tick();
            if (out_ready) begin
                eidx++;
            end
            c++;
        end
        chk("bp_all_bytes", eidx[15:0], 16'd16);
        chk("bp_end_valid", {15'd0, out_valid0}, 16'd0);
        chk("bp_blk_cnt", {8'd0, blk_cnt0}, 16'd2);

        // Back-to-back blocks with no gap
        out_ready = 1'b1;
        set_din(8'hA0, 8'h01);
        in_valid = 1'b1;
        tick();
        set_din(8'hB0, 8'h01);
        for (int i = 0; i < 32; i++) begin
            if (i == 31) begin
                in_valid = 1'b0;
                #1;
            end
            e0 = (i < 16) ? (8'hA0 + i[7:0]) : (8'hB0 + i[7:0] - 8'd16);
            chk("b2b_dout", {8'd0, dout0}, {8'd0, e0});
            chk("b2b_valid", {15'd0, out_valid0}, 16'd1);
            chk("b2b_in_ready", {15'd0, in_ready0}, {15'd0, (i == 15) || (i == 31)});
            chk("b2b_last", {15'd0, out_last0}, {15'd0, (i == 15) || (i == 31)});
            tick();
        end
        chk("b2b_end_valid", {15'd0, out_valid0}, 16'd0);
        chk("b2b_blk_cnt", {8'd0, blk_cnt0}, 16'd4);

        // Reset in the middle of a block
        set_din(8'h30, 8'h01);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("mid_dout", {8'd0, dout0}, {8'd0, 8'h30 + i[7:0]});
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {14'd0, out_valid0, out_valid1}, 16'd0);
        chk("mid_rst_blk_cnt", {8'd0, blk_cnt0}, 16'd0);
        chk("mid_rst_dout", {8'd0, dout0}, 16'd0);
        chk("mid_rst_in_ready", {15'd0, in_ready0}, 16'd1);
        tick();
        chk("mid_rst_stays_idle", {15'd0, out_valid0}, 16'd0);
        set_din(8'h40, 8'h01);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("post_rst_dout", {8'd0, dout0}, {8'd0, 8'h40 + i[7:0]});
            tick();
        end
        chk("post_rst_blk_cnt", {8'd0, blk_cnt0}, 16'd1);

        // Counter wrap over 257 blocks
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wrap_start", {8'd0, blk_cnt0}, 16'd0);
        set_din(8'h60, 8'h01);
        in_valid = 1'b1;
        repeat (16 * 256 + 1) tick();
        chk("wrap_256_cnt", {8'd0, blk_cnt0}, 16'd0);
        chk("wrap_256_valid", {15'd0, out_valid0}, 16'd1);
        in_valid = 1'b0;
        repeat (16) tick();
        chk("wrap_257_cnt0", {8'd0, blk_cnt0}, 16'd1);
        chk("wrap_257_cnt1", {8'd0, blk_cnt1}, 16'd1);
        chk("wrap_end_valid", {15'd0, out_valid0}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
